// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, derived totals/widths and a shared range decode helper.
package vga_pkg;
    localparam int   CLK_DIV_DEF     = 4;
    localparam int   H_VISIBLE_DEF   = 640;
    localparam int   H_FRONT_DEF     = 16;
    localparam int   H_SYNC_DEF      = 96;
    localparam int   H_BACK_DEF      = 48;
    localparam int   V_VISIBLE_DEF   = 480;
    localparam int   V_FRONT_DEF     = 10;
    localparam int   V_SYNC_DEF      = 2;
    localparam int   V_BACK_DEF      = 33;
    localparam logic SYNC_ACTIVE_DEF = 1'b0;
    localparam int   H_TOTAL_DEF     = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int   V_TOTAL_DEF     = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int   HW_DEF          = $clog2(H_TOTAL_DEF);
    localparam int   VW_DEF          = $clog2(V_TOTAL_DEF);

    function automatic logic in_range(input int val, input int lo, input int len);
        return (val >= lo) && (val < lo + len);
    endfunction
endpackage

// File: rtl/pix_tick_gen.sv
// pix_tick_gen: divides clk by CLK_DIV, tick_o high on the last count of each period.
module pix_tick_gen
    import vga_pkg::*;
#(
    parameter  int CLK_DIV = CLK_DIV_DEF,
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);
    logic [DW-1:0] div_q, div_d;

    assign tick_o = (div_q == DW'(CLK_DIV - 1));
    assign div_d  = tick_o ? '0 : div_q + DW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-rate h/v counters with registered sync, display-enable and start strobes.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter  int   CLK_DIV     = CLK_DIV_DEF,
    parameter  int   H_VISIBLE   = H_VISIBLE_DEF,
    parameter  int   H_FRONT     = H_FRONT_DEF,
    parameter  int   H_SYNC      = H_SYNC_DEF,
    parameter  int   H_BACK      = H_BACK_DEF,
    parameter  int   V_VISIBLE   = V_VISIBLE_DEF,
    parameter  int   V_FRONT     = V_FRONT_DEF,
    parameter  int   V_SYNC      = V_SYNC_DEF,
    parameter  int   V_BACK      = V_BACK_DEF,
    parameter  logic SYNC_ACTIVE = SYNC_ACTIVE_DEF,
    localparam int   H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int   V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int   HW          = $clog2(H_TOTAL),
    localparam int   VW          = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          hsync,
    output logic          vsync,
    output logic          read_pixel,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          line_start,
    output logic          frame_start
);
    logic          tick, h_wrap, v_wrap;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hsync_q, vsync_q, read_q, line_q, frame_q;

    pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign h_wrap = tick && (h_q == HW'(H_TOTAL - 1));
    assign v_wrap = h_wrap && (v_q == VW'(V_TOTAL - 1));

    always_comb begin
        h_d = h_wrap ? '0 : (tick ? h_q + HW'(1) : h_q);
        v_d = v_wrap ? '0 : (h_wrap ? v_q + VW'(1) : v_q);
    end

    // Decode from next-state counters so every output lines up with the counts it is registered alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= HW'(H_TOTAL - 1);
            v_q     <= VW'(V_TOTAL - 1);
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
            read_q  <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= in_range(int'(h_d), H_VISIBLE + H_FRONT, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q <= in_range(int'(v_d), V_VISIBLE + V_FRONT, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            read_q  <= (h_d < HW'(H_VISIBLE)) && (v_d < VW'(V_VISIBLE));
            line_q  <= h_wrap;
            frame_q <= v_wrap;
        end
    end

    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign read_pixel  = read_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
endmodule
